// File: rtl/hazard_ctrl_p.sv
// Central hazard unit for the 5-stage pipeline: forwarding select, load-use interlock,
// branch-redirect flush, miss-wait FSM with timeout, and saturating performance counters.
module hazard_ctrl_p #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MISS_MAX = 255
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] i_ex_rs1,
  input  logic [REG_AW-1:0] i_ex_rs2,
  input  logic              i_ex_need_rs1,
  input  logic              i_ex_need_rs2,
  input  logic [REG_AW-1:0] i_ma_rdst,
  input  logic              i_ma_we,
  input  logic              i_ma_load,
  input  logic [REG_AW-1:0] i_wb_rdst,
  input  logic              i_wb_we,
  input  logic              i_redirect,
  input  logic              i_imiss,
  input  logic              i_dmiss,
  input  logic              i_cnt_clr,
  output logic [1:0]        o_fwd1,
  output logic [1:0]        o_fwd2,
  output logic              o_pc_stall,
  output logic              o_ifid_stall,
  output logic              o_ifid_flush,
  output logic              o_idex_stall,
  output logic              o_idex_flush,
  output logic              o_exma_stall,
  output logic              o_exma_flush,
  output logic              o_mawb_flush,
  output logic              o_miss_err,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_loaduse_cnt,
  output logic [CNT_W-1:0]  o_redirect_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DMISS = 2'd1;
  localparam logic [1:0] ST_IMISS = 2'd2;

  localparam int unsigned MW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  logic          ma_hit1, ma_hit2, wb_hit1, wb_hit2;
  logic          lu, lu_act, redir_acc, im_act;
  logic          pc_stall;
  logic [1:0]    fwd1, fwd2;
  logic [1:0]    state_q, state_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic          err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    ma_hit1 = i_ex_need_rs1 && i_ma_we && (i_ma_rdst == i_ex_rs1) && (i_ex_rs1 != '0);
    ma_hit2 = i_ex_need_rs2 && i_ma_we && (i_ma_rdst == i_ex_rs2) && (i_ex_rs2 != '0);
    wb_hit1 = i_ex_need_rs1 && i_wb_we && (i_wb_rdst == i_ex_rs1) && (i_ex_rs1 != '0);
    wb_hit2 = i_ex_need_rs2 && i_wb_we && (i_wb_rdst == i_ex_rs2) && (i_ex_rs2 != '0);

    fwd1 = 2'b00;
    if (ma_hit1 && !i_ma_load) fwd1 = 2'b01;
    else if (wb_hit1)          fwd1 = 2'b10;
    fwd2 = 2'b00;
    if (ma_hit2 && !i_ma_load) fwd2 = 2'b01;
    else if (wb_hit2)          fwd2 = 2'b10;

    // Priority chain: D-miss > load-use > redirect > I-miss, all from current inputs
    lu        = (ma_hit1 || ma_hit2) && i_ma_load;
    lu_act    = !i_dmiss && lu;
    redir_acc = !i_dmiss && !lu && i_redirect;
    im_act    = !i_dmiss && !lu && !i_redirect && i_imiss;
    pc_stall  = i_dmiss || lu_act || im_act;
  end

  assign o_fwd1        = Rst ? fwd1 : 2'b00;
  assign o_fwd2        = Rst ? fwd2 : 2'b00;
  assign o_pc_stall    = Rst && pc_stall;
  assign o_ifid_stall  = Rst && (i_dmiss || lu_act);
  assign o_ifid_flush  = Rst && (redir_acc || im_act);
  assign o_idex_stall  = Rst && (i_dmiss || lu_act);
  assign o_idex_flush  = Rst && redir_acc;
  assign o_exma_stall  = Rst && i_dmiss;
  assign o_exma_flush  = Rst && lu_act;
  assign o_mawb_flush  = Rst && i_dmiss;
  assign o_miss_err    = err_q;
  assign o_stall_cnt    = stall_cnt_q;
  assign o_loaduse_cnt  = lu_cnt_q;
  assign o_redirect_cnt = rd_cnt_q;

  always_comb begin
    state_d = i_dmiss ? ST_DMISS : (i_imiss ? ST_IMISS : ST_RUN);

    // Miss counter restarts on every state change, including DMISS -> IMISS
    mcnt_d = mcnt_q;
    if (state_d != state_q)                    mcnt_d = '0;
    else if (state_q != ST_RUN && mcnt_q != '1) mcnt_d = mcnt_q + MW'(1);

    err_d = err_q || ((MISS_MAX != 0) && (mcnt_q == MW'(MISS_MAX)));

    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      lu_cnt_d    = '0;
      rd_cnt_d    = '0;
    end else begin
      if (pc_stall  && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (lu_act    && lu_cnt_q    != '1) lu_cnt_d    = lu_cnt_q + CNT_W'(1);
      if (redir_acc && rd_cnt_q    != '1) rd_cnt_d    = rd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= ST_RUN;
      mcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mcnt_q      <= mcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

endmodule

// File: doc/hazard_ctrl_p.md
Name: hazard_ctrl_p

Overview:
Parametrised successor to the current hazard unit for the 5-stage IF/ID/EX/MA/WB pipeline. Combines four functions: operand forwarding selection, load-use interlock, branch-redirect flush, and a miss-wait state machine with timeout detection. It also provides saturating performance counters. It drives every stall and flush line of the pipeline registers from one place, with a registered miss FSM.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero and never forwarded or interlocked.
CNT_W, 16, width of each performance counter.
MISS_MAX, 255, cycles a miss may persist before o_miss_err is set; 0 disables the timeout.

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous active-low reset
i_ex_rs1, i_ex_rs2  in  REG_AW  source regs of the instruction in EX
i_ex_need_rs1, i_ex_need_rs2  in  1  source is actually read
i_ma_rdst  in  REG_AW  dest reg in EX/MA
i_ma_we  in  1  EX/MA register-write enable
i_ma_load  in  1  EX/MA holds a load (mem enabled, read, WB mux = memory)
i_wb_rdst  in  REG_AW  dest reg in MA/WB
i_wb_we  in  1  MA/WB register-write enable
i_redirect  in  1  branch unit: mispredict/jump resolved in EX
i_imiss, i_dmiss  in  1  I-cache / D-cache miss, level, held until fill
i_cnt_clr  in  1  synchronous clear of all counters
o_fwd1, o_fwd2  out  2  00 regfile, 01 from MA ALU result, 10 from WB mux
o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush, o_exma_stall, o_exma_flush, o_mawb_flush  out  1 each  pipeline control
o_miss_err  out  1  sticky: a miss exceeded MISS_MAX
o_stall_cnt, o_loaduse_cnt, o_redirect_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (Rst=0, async): FSM=RUN, miss counter=0, o_miss_err=0, all counters=0. All stall/flush outputs are 0 while in reset; o_fwd*=00.
- Forwarding (combinational; src = rs1 or rs2):
  - MA match: need && ma_we && !ma_load && ma_rdst==src && src!=0 → 01.
  - Else WB match: need && wb_we && wb_rdst==src && src!=0 → 10.
  - Otherwise 00. An MA match has priority over a WB match.
- Load-use (LU): need && ma_we && ma_load && ma_rdst==src && src!=0, for either source.
- FSM states: RUN, DMISS, IMISS. Output priority within any cycle, highest first: DMISS > LU > redirect > IMISS.
  - DMISS, entered or held whenever i_dmiss=1 (from any state):
    - pc/ifid/idex/exma stall=1; mawb_flush=1; all other flushes 0.
    - Redirect is ignored; the branch remains in EX and re-presents it.
  - LU, in RUN or IMISS with i_dmiss=0:
    - pc/ifid/idex stall=1; exma_flush=1 (one bubble).
    - Redirect is suppressed this cycle; the next cycle forwards from WB.
  - Redirect accepted (no dmiss, no LU):
    - ifid_flush=1; idex_flush=1; pc_stall=0, so PC loads the target even during IMISS, abandoning the fetch.
    - FSM → RUN next cycle if i_imiss=0.
  - IMISS, while i_imiss=1 with none of the above:
    - pc_stall=1; ifid_flush=1 (bubble into ID); downstream proceeds.
  - Transitions:
    - RUN → DMISS on i_dmiss; RUN → IMISS on i_imiss and not i_dmiss.
    - DMISS → IMISS when i_dmiss falls while i_imiss=1; DMISS → RUN when i_dmiss falls and i_imiss=0.
    - IMISS → RUN when i_imiss falls.
- Miss counter:
  - Clears on each state entry; increments each cycle in DMISS or IMISS; saturates.
  - When it equals MISS_MAX (MISS_MAX≠0), o_miss_err←1 on the next edge, cleared only by reset. The stall behaviour itself is unchanged.
- Counters: each cycle, +1 as follows.
  - o_stall_cnt: cycles with o_pc_stall=1.
  - o_loaduse_cnt: LU cycles that actually produce a bubble (not DMISS cycles).
  - o_redirect_cnt: accepted redirects.
  - All saturate at 2^CNT_W−1. i_cnt_clr has priority over increment.
- Reset mid-miss: FSM returns to RUN immediately and outputs drop to 0. o_miss_err is cleared.

Test Plan:
- Forwarding priority: rs1=3 need; MA writes r3 (ALU), WB writes r3 → o_fwd1=01. Remove MA → 10. rs1=0 in both → 00.
- Load-use: MA load to r5, EX needs rs2=5 → one cycle of pc/ifid/idex stall=1, exma_flush=1, o_loaduse_cnt 0→1. Next cycle (load now in WB) → o_fwd2=10, no stall.
- D-miss with redirect: i_dmiss high 4 cycles with i_redirect=1 → 4 cycles full stall plus mawb_flush, no ifid/idex flush, o_redirect_cnt unchanged. On the cycle i_dmiss drops → flushes fire, o_redirect_cnt=1.
- I-miss abandoned by redirect: i_imiss=1 for 3 cycles, then i_redirect=1 → pc_stall=0, ifid_flush=idex_flush=1 on the 4th cycle. FSM→RUN after i_imiss drops.
- Timeout: MISS_MAX=8, i_dmiss held 20 cycles → o_miss_err=1 from the 10th edge onward. Still 1 after i_dmiss falls; cleared only by Rst=0.
- Counter saturation/clear: CNT_W=4, 20 stall cycles → o_stall_cnt=15. Pulse i_cnt_clr during a stall → 0 that edge, then 1.
